// File: rtl/tensor_hgmma_warp_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tensor_hgmma_warp_arbiter
// Purpose : Round-robin arbiter sharing one tensor core among HGMMA warps,
//           with per-warp outstanding-HGMMA tracking from writeback snoops.
//           Optional macro TENSOR_HGMMA_ARB_PERF_EN adds grant/stall counters.
// Revision: 1.0 - initial release
// ============================================================================
module tensor_hgmma_warp_arbiter #(
    parameter int NUM_WARPS       = 4,
    parameter int MAX_OUTSTANDING = 2,
    localparam int NW_WIDTH       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int CNTW           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WARPS-1:0] req_valid,
    output logic [NUM_WARPS-1:0] req_ready,
    output logic                 core_init_valid,
    output logic [NW_WIDTH-1:0]  core_init_wid,
    input  logic                 core_init_ready,
    input  logic                 core_wb_fire,
    input  logic [NW_WIDTH-1:0]  core_wb_wid,
    input  logic                 core_wb_last,
`ifdef TENSOR_HGMMA_ARB_PERF_EN
    output logic [31:0]          perf_grants,
    output logic [31:0]          perf_stall_cycles,
`endif
    output logic [NUM_WARPS-1:0] pending,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NW_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [NW_WIDTH-1:0] lat_wid_q, lat_wid_d;
    logic [CNTW-1:0]     cnt_q [NUM_WARPS];
    logic [CNTW-1:0]     cnt_d [NUM_WARPS];
    logic                err_q, err_d;

    logic [NUM_WARPS-1:0] eligible;
    logic                 found;
    logic [NW_WIDTH-1:0]  winner;
    logic                 accept;
    logic                 wb_in_range;
    logic                 retire;
    logic [NW_WIDTH-1:0]  scan_idx;

`ifdef TENSOR_HGMMA_ARB_PERF_EN
    logic [31:0] perf_grants_q, perf_grants_d;
    logic [31:0] perf_stall_q, perf_stall_d;
`endif

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            eligible[i] = req_valid[i] && (cnt_q[i] < CNTW'(MAX_OUTSTANDING));
        end

        // Rotating scan starting at rr_ptr; first hit wins.
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_WARPS; k++) begin
            scan_idx = NW_WIDTH'((int'(rr_ptr_q) + k) % NUM_WARPS);
            if (!found && eligible[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end

        accept    = (state_q == IDLE) && found;
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lat_wid_d = lat_wid_q;
        err_d     = err_q;

        wb_in_range = int'(core_wb_wid) < NUM_WARPS;
        retire      = core_wb_fire && core_wb_last && wb_in_range;
        if (core_wb_fire && !wb_in_range) begin
            err_d = 1'b1;
        end

        // A same-cycle accept and retire on one warp cancel out.
        for (int i = 0; i < NUM_WARPS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept && (winner == NW_WIDTH'(i)) &&
                !(retire && (core_wb_wid == NW_WIDTH'(i)))) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (retire && (core_wb_wid == NW_WIDTH'(i)) &&
                         !(accept && (winner == NW_WIDTH'(i)))) begin
                if (cnt_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    lat_wid_d = winner;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (core_init_ready) begin
                    rr_ptr_d = NW_WIDTH'((int'(lat_wid_q) + 1) % NUM_WARPS);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef TENSOR_HGMMA_ARB_PERF_EN
    always_comb begin
        perf_grants_d = perf_grants_q + {31'd0, accept};
        perf_stall_d  = perf_stall_q +
                        {31'd0, (state_q == ISSUE) && !core_init_ready};
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            lat_wid_q <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < NUM_WARPS; i++) begin
                cnt_q[i] <= '0;
            end
`ifdef TENSOR_HGMMA_ARB_PERF_EN
            perf_grants_q <= '0;
            perf_stall_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lat_wid_q <= lat_wid_d;
            err_q     <= err_d;
            for (int i = 0; i < NUM_WARPS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
`ifdef TENSOR_HGMMA_ARB_PERF_EN
            perf_grants_q <= perf_grants_d;
            perf_stall_q  <= perf_stall_d;
`endif
        end
    end

    always_comb begin
        core_init_valid = (state_q == ISSUE);
        core_init_wid   = lat_wid_q;
        busy            = (state_q == ISSUE);
        err             = err_q;
        for (int i = 0; i < NUM_WARPS; i++) begin
            pending[i] = (cnt_q[i] != '0);
        end
    end

`ifdef TENSOR_HGMMA_ARB_PERF_EN
    assign perf_grants       = perf_grants_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tensor_hgmma_warp_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_tensor_hgmma_warp_arbiter
// Purpose : Directed and random checks of the HGMMA warp arbiter against a
//           count-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tensor_hgmma_warp_arbiter;

    localparam int NW  = 4;
    localparam int MAX = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [NW-1:0] req_valid;
    logic [NW-1:0] req_ready;
    logic          core_init_valid;
    logic [1:0]    core_init_wid;
    logic          core_init_ready;
    logic          core_wb_fire;
    logic [1:0]    core_wb_wid;
    logic          core_wb_last;
    logic [NW-1:0] pending;
    logic          busy;
    logic          err;
`ifdef TENSOR_HGMMA_ARB_PERF_EN
    logic [31:0]   perf_grants;
    logic [31:0]   perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    tensor_hgmma_warp_arbiter #(.NUM_WARPS(NW), .MAX_OUTSTANDING(MAX)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .core_init_valid (core_init_valid),
        .core_init_wid   (core_init_wid),
        .core_init_ready (core_init_ready),
        .core_wb_fire    (core_wb_fire),
        .core_wb_wid     (core_wb_wid),
        .core_wb_last    (core_wb_last),
`ifdef TENSOR_HGMMA_ARB_PERF_EN
        .perf_grants       (perf_grants),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .pending         (pending),
        .busy            (busy),
        .err             (err)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Reference model: outstanding counts, issue slot, pointer, sticky error.
    int m_cnt [NW];
    bit m_busy;
    int m_rr;
    int m_lat;
    bit m_err;
    int m_grants;
    int m_stall;
    int last_grant;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NW-1:0] rv);
        for (int k = 0; k < NW; k++) begin
            int idx;
            idx = (m_rr + k) % NW;
            if (rv[idx] && m_cnt[idx] < MAX) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NW; i++) m_cnt[i] = 0;
        m_busy = 0; m_rr = 0; m_lat = 0; m_err = 0;
        m_grants = 0; m_stall = 0; last_grant = -1;
    endtask

    task automatic check_outputs(input int w);
        logic [NW-1:0] exp_rr;
        logic [NW-1:0] exp_pend;
        exp_rr = '0;
        if (w >= 0) exp_rr[w] = 1'b1;
        for (int i = 0; i < NW; i++) exp_pend[i] = (m_cnt[i] != 0);
        chk("req_ready", 32'(req_ready), 32'(exp_rr));
        chk("core_init_valid", 32'(core_init_valid), 32'(m_busy));
        if (m_busy) chk("core_init_wid", 32'(core_init_wid), 32'(m_lat));
        chk("pending", 32'(pending), 32'(exp_pend));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("err", 32'(err), 32'(m_err));
`ifdef TENSOR_HGMMA_ARB_PERF_EN
        chk("perf_grants", perf_grants, 32'(m_grants));
        chk("perf_stall_cycles", perf_stall_cycles, 32'(m_stall));
`endif
    endtask

    task automatic cycle(input logic [NW-1:0] rv, input logic rdy, input logic fire,
                         input logic [1:0] wid, input logic last);
        int w;
        @(negedge clk);
        req_valid = rv; core_init_ready = rdy; core_wb_fire = fire;
        core_wb_wid = wid; core_wb_last = last;
        #1;
        w = m_busy ? -1 : pick(rv);
        check_outputs(w);
        last_grant = w;
        @(posedge clk);
        for (int i = 0; i < NW; i++) begin
            int n;
            n = m_cnt[i] + ((w == i) ? 1 : 0) - ((fire && last && int'(wid) == i) ? 1 : 0);
            if (n < 0) begin
                n = 0;
                m_err = 1;
            end
            m_cnt[i] = n;
        end
        if (w >= 0) begin
            m_busy = 1; m_lat = w; m_grants++;
        end else if (m_busy) begin
            if (rdy) begin
                m_busy = 0; m_rr = (m_lat + 1) % NW;
            end else begin
                m_stall++;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        req_valid = '0; core_init_ready = 1'b0; core_wb_fire = 1'b0;
        core_wb_wid = '0; core_wb_last = 1'b0;
        #1;
        model_reset();
        check_outputs(-1);
        chk("reset_wid", 32'(core_init_wid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        model_reset();
        apply_reset();

        // Single request, then its retire
        cycle(4'b0001, 1, 0, 0, 0);
        chk("single_grant", 32'(last_grant), 32'd0);
        cycle(4'b0000, 1, 0, 0, 0);
        chk("single_valid", 32'(core_init_valid), 32'd1);
        cycle(4'b0000, 1, 1, 0, 1);
        cycle(4'b0000, 1, 0, 0, 0);
        chk("single_pending_clear", 32'(pending), 32'd0);

        // Round-robin until every warp is full
        apply_reset();
        for (int g = 0; g < 8; g++) begin
            cycle(4'b1111, 1, 0, 0, 0);
            chk("rr_grant", 32'(last_grant), 32'(g % NW));
            cycle(4'b1111, 1, 0, 0, 0);
        end
        cycle(4'b1111, 1, 0, 0, 0);
        chk("rr_all_full", 32'(req_ready), 32'd0);
        chk("rr_pending", 32'(pending), 32'hf);

        // Backpressure on warp 2
        apply_reset();
        cycle(4'b0100, 1, 0, 0, 0);
        for (int s = 0; s < 5; s++) begin
            cycle(4'b1111, 0, 0, 0, 0);
            chk("bp_wid", 32'(core_init_wid), 32'd2);
        end
        cycle(4'b0000, 1, 0, 0, 0);
        cycle(4'b1111, 1, 0, 0, 0);
        chk("bp_next_rr", 32'(last_grant), 32'd3);

        // Full warp 1 is skipped with rr_ptr at 1
        apply_reset();
        cycle(4'b0010, 1, 0, 0, 0); cycle(4'b0000, 1, 0, 0, 0);
        cycle(4'b0010, 1, 0, 0, 0); cycle(4'b0000, 1, 0, 0, 0);
        cycle(4'b0001, 1, 0, 0, 0); cycle(4'b0000, 1, 0, 0, 0);
        cycle(4'b0110, 1, 0, 0, 0);
        chk("full_skip", 32'(last_grant), 32'd2);

        // Accept and retire on warp 0 in the same cycle
        apply_reset();
        cycle(4'b0001, 1, 0, 0, 0); cycle(4'b0000, 1, 0, 0, 0);
        cycle(4'b0001, 1, 1, 0, 1);
        chk("simul_grant", 32'(last_grant), 32'd0);
        cycle(4'b0000, 1, 0, 0, 0);
        chk("simul_pending0", 32'(pending[0]), 32'd1);
        chk("simul_err", 32'(err), 32'd0);

        // Retire with zero count, then asynchronous reset while issuing
        apply_reset();
        cycle(4'b0000, 1, 1, 3, 1);
        cycle(4'b1000, 0, 0, 0, 0);
        chk("underflow_err", 32'(err), 32'd1);
        chk("underflow_pending", 32'(pending), 32'd0);
        cycle(4'b0000, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_valid", 32'(core_init_valid), 32'd0);
        chk("async_err", 32'(err), 32'd0);
        chk("async_pending", 32'(pending), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (i == 200) apply_reset();
            cycle(4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  2'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
